toy_ld_align: RTL and testbench

TOY_LD_ALIGN -- requirements
Module: toy_ld_align

---
 rtl/toy_ld_align_if.sv | 30 +++
 rtl/toy_ld_align.sv | 119 +++++++++++
 tb/tb_toy_ld_align.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/toy_ld_align_if.sv
// rtl/toy_ld_align_if.sv - load response / writeback bus bundle for toy_ld_align
interface toy_ld_align_if #(
   parameter int DATA_WIDTH = 32,
   parameter int SB_WIDTH   = 22
);
   logic                  s_ack_vld;
   logic                  s_ack_rdy;
   logic [DATA_WIDTH-1:0] s_ack_data;
   logic [SB_WIDTH-1:0]   s_ack_sideband;
   logic                  m_wb_vld;
   logic                  m_wb_rdy;
   logic [DATA_WIDTH-1:0] m_wb_data;
   logic [5:0]            m_wb_rd;
   logic [5:0]            m_wb_inst_id;
   logic                  m_wb_int_en;
   logic                  m_wb_fp_en;
   logic                  m_wb_err;

   modport master (
      output s_ack_vld, s_ack_data, s_ack_sideband, m_wb_rdy,
      input  s_ack_rdy, m_wb_vld, m_wb_data, m_wb_rd, m_wb_inst_id,
             m_wb_int_en, m_wb_fp_en, m_wb_err
   );

   modport slave (
      input  s_ack_vld, s_ack_data, s_ack_sideband, m_wb_rdy,
      output s_ack_rdy, m_wb_vld, m_wb_data, m_wb_rd, m_wb_inst_id,
             m_wb_int_en, m_wb_fp_en, m_wb_err
   );
endinterface

// File: rtl/toy_ld_align.sv
// rtl/toy_ld_align.sv - load data aligner/extender with 2-entry writeback FIFO and load counter
module toy_ld_align #(
   parameter int DATA_WIDTH      = 32,
   parameter int SB_WIDTH        = 22,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         s_req_fire,
   toy_ld_align_if.slave bus,
   output logic [2:0]   ld_cnt,
   output logic         req_credit
);
   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [5:0]            rd;
      logic [5:0]            inst_id;
      logic                  int_en;
      logic                  fp_en;
      logic                  err;
   } entry_t;

   entry_t                mem [2];
   entry_t                new_e;
   entry_t                head;
   logic [1:0]            count;
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic                  ack_fire;
   logic                  wb_fire;
   logic [1:0]            off;
   logic [2:0]            funct3;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] val;
   logic                  bad;
   logic                  unused_sb;

   assign unused_sb = ^bus.s_ack_sideband[SB_WIDTH-1:19];

   assign off     = bus.s_ack_sideband[18:17];
   assign funct3  = bus.s_ack_sideband[2:0];
   assign shifted = bus.s_ack_data >> {off, 3'b000};

   always_comb begin
      val = '0;
      bad = 1'b0;
      case (funct3)
         3'b000: val = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
         3'b100: val = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
         3'b001: begin
            bad = (off == 2'd3);
            val = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
         end
         3'b101: begin
            bad = (off == 2'd3);
            val = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
         end
         3'b010: begin
            bad = (off != 2'd0);
            val = bus.s_ack_data;
         end
         default: bad = 1'b1;
      endcase
   end

   // Faulting loads still carry rd/inst_id so the pipeline can retire them with an exception.
   always_comb begin
      new_e         = '0;
      new_e.data    = bad ? '0 : val;
      new_e.rd      = bus.s_ack_sideband[10:5];
      new_e.inst_id = bus.s_ack_sideband[16:11];
      new_e.int_en  = ~bad & bus.s_ack_sideband[4];
      new_e.fp_en   = ~bad & bus.s_ack_sideband[3];
      new_e.err     = bad;
   end

   assign bus.s_ack_rdy = ~count[1];
   assign bus.m_wb_vld  = (count != 2'd0);
   assign ack_fire      = bus.s_ack_vld & bus.s_ack_rdy;
   assign wb_fire       = bus.m_wb_vld & bus.m_wb_rdy;

   assign head              = bus.m_wb_vld ? mem[rd_ptr] : '0;
   assign bus.m_wb_data     = head.data;
   assign bus.m_wb_rd       = head.rd;
   assign bus.m_wb_inst_id  = head.inst_id;
   assign bus.m_wb_int_en   = head.int_en;
   assign bus.m_wb_fp_en    = head.fp_en;
   assign bus.m_wb_err      = head.err;

   assign req_credit = (ld_cnt < 3'(MAX_OUTSTANDING));

   always_ff @(posedge clk) begin
      if (rst_n && ack_fire) begin
         mem[wr_ptr] <= new_e;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         ld_cnt <= 3'd0;
      end else begin
         if (ack_fire) wr_ptr <= ~wr_ptr;
         if (wb_fire)  rd_ptr <= ~rd_ptr;
         case ({ack_fire, wb_fire})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (s_req_fire && !wb_fire && (ld_cnt < 3'(MAX_OUTSTANDING))) begin
            ld_cnt <= ld_cnt + 3'd1;
         end else if (wb_fire && !s_req_fire && (ld_cnt != 3'd0)) begin
            ld_cnt <= ld_cnt - 3'd1;
         end
      end
   end
endmodule

// File: tb/tb_toy_ld_align.sv
// tb/tb_toy_ld_align.sv - self-checking bench for toy_ld_align
module tb_toy_ld_align;
   logic       clk;
   logic       rst_n;
   logic       s_req_fire;
   logic [2:0] ld_cnt;
   logic       req_credit;
   int         checks;
   int         errors;
   bit         chk_en;

   typedef struct {
      logic [31:0] data;
      logic [5:0]  rd;
      logic [5:0]  id;
      logic        ie;
      logic        fe;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   mld;

   toy_ld_align_if #(.DATA_WIDTH(32), .SB_WIDTH(22)) bus ();

   toy_ld_align #(.DATA_WIDTH(32), .SB_WIDTH(22), .MAX_OUTSTANDING(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_req_fire (s_req_fire),
      .bus        (bus),
      .ld_cnt     (ld_cnt),
      .req_credit (req_credit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [21:0] mk_sb(input logic [2:0] f3, input logic fp, input logic in,
                                         input logic [5:0] rd, input logic [5:0] id, input logic [4:0] addr);
      return {addr, id, rd, in, fp, f3};
   endfunction

   // Expected writeback from the load rules using plain integer arithmetic.
   function automatic exp_t model_wb(input logic [31:0] d, input logic [21:0] sb);
      exp_t        e;
      int          off;
      int          f3;
      longint      v;
      bit          bad;
      logic [31:0] sh;
      off = int'(sb[18:17]);
      f3  = int'(sb[2:0]);
      sh  = d >> (8 * off);
      bad = 1'b0;
      v   = 0;
      if (f3 == 0 || f3 == 4) begin
         v = longint'(sh % 256);
         if (f3 == 0 && v >= 128) v = v - 256;
      end else if (f3 == 1 || f3 == 5) begin
         bad = (off == 3);
         v = longint'(sh % 65536);
         if (f3 == 1 && v >= 32768) v = v - 65536;
      end else if (f3 == 2) begin
         bad = (off != 0);
         v = longint'(d);
      end else begin
         bad = 1'b1;
      end
      e.data = bad ? 32'd0 : v[31:0];
      e.rd   = sb[10:5];
      e.id   = sb[16:11];
      e.ie   = bad ? 1'b0 : sb[4];
      e.fe   = bad ? 1'b0 : sb[3];
      e.err  = bad;
      return e;
   endfunction

   always @(posedge clk) begin
      bit wb;
      bit ack;
      if (!rst_n) begin
         q.delete();
         mld = 0;
      end else begin
         wb  = (q.size() > 0) && bus.m_wb_rdy;
         ack = bus.s_ack_vld && (q.size() < 2);
         if (wb) void'(q.pop_front());
         if (ack) q.push_back(model_wb(bus.s_ack_data, bus.s_ack_sideband));
         if (s_req_fire && !wb) mld = (mld + 1 > 4) ? 4 : mld + 1;
         if (wb && !s_req_fire) mld = (mld - 1 < 0) ? 0 : mld - 1;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (chk_en) begin
         if (q.size() > 0) e = q[0];
         else e = '{data: 32'd0, rd: 6'd0, id: 6'd0, ie: 1'b0, fe: 1'b0, err: 1'b0};
         chk("wb_vld",     32'(bus.m_wb_vld),     32'(q.size() > 0));
         chk("ack_rdy",    32'(bus.s_ack_rdy),    32'(q.size() < 2));
         chk("ld_cnt",     32'(ld_cnt),           32'(mld));
         chk("req_credit", 32'(req_credit),       32'(mld < 4));
         chk("wb_data",    bus.m_wb_data,         e.data);
         chk("wb_rd",      32'(bus.m_wb_rd),      32'(e.rd));
         chk("wb_inst_id", 32'(bus.m_wb_inst_id), 32'(e.id));
         chk("wb_int_en",  32'(bus.m_wb_int_en),  32'(e.ie));
         chk("wb_fp_en",   32'(bus.m_wb_fp_en),   32'(e.fe));
         chk("wb_err",     32'(bus.m_wb_err),     32'(e.err));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic ack(input logic [31:0] d, input logic [21:0] sb);
      bus.s_ack_vld      = 1'b1;
      bus.s_ack_data     = d;
      bus.s_ack_sideband = sb;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      chk_en = 1'b0;
      rst_n = 1'b0;
      s_req_fire = 1'b0;
      bus.s_ack_vld = 1'b0;
      bus.s_ack_data = '0;
      bus.s_ack_sideband = '0;
      bus.m_wb_rdy = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_ack_rdy", 32'(bus.s_ack_rdy), 32'd1);
      chk("rst_wb_vld",  32'(bus.m_wb_vld),  32'd0);
      chk("rst_wb_data", bus.m_wb_data,      32'd0);
      chk("rst_ld_cnt",  32'(ld_cnt),        32'd0);
      chk("rst_credit",  32'(req_credit),    32'd1);
      rst_n = 1'b1;
      tick();

      // LB off=2, then LHU off=2, then LH off=3
      bus.m_wb_rdy = 1'b1;
      ack(32'h12F45678, mk_sb(3'b000, 1'b0, 1'b1, 6'd5, 6'd9, 5'd2));
      tick();
      ack(32'h80010000, mk_sb(3'b101, 1'b0, 1'b1, 6'd7, 6'd10, 5'd2));
      chk("lb_data",   bus.m_wb_data,         32'hFFFFFFF4);
      chk("lb_rd",     32'(bus.m_wb_rd),      32'd5);
      chk("lb_int_en", 32'(bus.m_wb_int_en),  32'd1);
      chk("lb_err",    32'(bus.m_wb_err),     32'd0);
      tick();
      ack(32'hDEADBEEF, mk_sb(3'b001, 1'b0, 1'b1, 6'd8, 6'd11, 5'd3));
      chk("lhu_data",  bus.m_wb_data,         32'h00008001);
      tick();
      bus.s_ack_vld = 1'b0;
      chk("lh3_err",    32'(bus.m_wb_err),    32'd1);
      chk("lh3_data",   bus.m_wb_data,        32'd0);
      chk("lh3_int_en", 32'(bus.m_wb_int_en), 32'd0);
      chk("lh3_rd",     32'(bus.m_wb_rd),     32'd8);
      tick();

      // three back-to-back acks into a stalled consumer
      bus.m_wb_rdy = 1'b0;
      ack(32'hA0A0A0A0, mk_sb(3'b010, 1'b1, 1'b0, 6'd1, 6'd1, 5'd0));
      tick();
      ack(32'h00009900, mk_sb(3'b100, 1'b0, 1'b1, 6'd2, 6'd2, 5'd1));
      tick();
      ack(32'hCCCC0001, mk_sb(3'b010, 1'b0, 1'b1, 6'd3, 6'd3, 5'd4));
      tick();
      chk("full_ack_rdy", 32'(bus.s_ack_rdy), 32'd0);
      chk("full_head",    bus.m_wb_data,      32'hA0A0A0A0);
      chk("full_fp_en",   32'(bus.m_wb_fp_en), 32'd1);
      bus.m_wb_rdy = 1'b1;
      tick();
      chk("rel1_data",    bus.m_wb_data,      32'h00000099);
      chk("rel1_ack_rdy", 32'(bus.s_ack_rdy), 32'd1);
      tick();
      bus.s_ack_vld = 1'b0;
      chk("rel2_data",    bus.m_wb_data,      32'hCCCC0001);
      tick();
      chk("drained_vld",  32'(bus.m_wb_vld),  32'd0);
      chk("ld_floor",     32'(ld_cnt),        32'd0);

      // ld_cnt saturation and simultaneous fire/writeback
      bus.m_wb_rdy = 1'b0;
      s_req_fire = 1'b1;
      repeat (6) tick();
      s_req_fire = 1'b0;
      chk("sat_ld_cnt", 32'(ld_cnt),     32'd4);
      chk("sat_credit", 32'(req_credit), 32'd0);
      ack(32'h11111111, mk_sb(3'b010, 1'b0, 1'b1, 6'd4, 6'd4, 5'd0));
      tick();
      bus.s_ack_vld = 1'b0;
      bus.m_wb_rdy = 1'b1;
      tick();
      chk("dec_ld_cnt", 32'(ld_cnt), 32'd3);
      bus.m_wb_rdy = 1'b0;
      ack(32'h22222222, mk_sb(3'b010, 1'b0, 1'b1, 6'd6, 6'd6, 5'd0));
      tick();
      bus.s_ack_vld = 1'b0;
      s_req_fire = 1'b1;
      bus.m_wb_rdy = 1'b1;
      tick();
      s_req_fire = 1'b0;
      bus.m_wb_rdy = 1'b0;
      chk("both_ld_cnt", 32'(ld_cnt), 32'd3);

      // reset with a full FIFO and ld_cnt=3
      ack(32'h33333333, mk_sb(3'b010, 1'b0, 1'b1, 6'd9, 6'd9, 5'd0));
      tick();
      ack(32'h44444444, mk_sb(3'b010, 1'b0, 1'b1, 6'd10, 6'd10, 5'd0));
      tick();
      chk("pre_rst_rdy", 32'(bus.s_ack_rdy), 32'd0);
      rst_n = 1'b0;
      s_req_fire = 1'b1;
      bus.m_wb_rdy = 1'b1;
      tick();
      chk("mid_rst_vld",  32'(bus.m_wb_vld),  32'd0);
      chk("mid_rst_ld",   32'(ld_cnt),        32'd0);
      chk("mid_rst_rdy",  32'(bus.s_ack_rdy), 32'd1);
      chk("mid_rst_data", bus.m_wb_data,      32'd0);
      rst_n = 1'b1;
      s_req_fire = 1'b0;
      bus.s_ack_vld = 1'b0;
      bus.m_wb_rdy = 1'b0;
      tick();

      for (int i = 0; i < 10000; i++) begin
         bus.s_ack_vld      = ($urandom_range(0, 3) != 0);
         bus.s_ack_data     = $urandom;
         bus.s_ack_sideband = 22'($urandom);
         bus.m_wb_rdy       = ($urandom_range(0, 2) != 0);
         s_req_fire         = ($urandom_range(0, 2) == 0);
         tick();
      end
      bus.s_ack_vld = 1'b0;
      s_req_fire = 1'b0;
      bus.m_wb_rdy = 1'b1;
      tick();
      tick();
      chk("final_vld", 32'(bus.m_wb_vld), 32'd0);
      chk("final_rdy", 32'(bus.s_ack_rdy), 32'd1);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
